// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map, bit positions and FSM states for spi_fifo_master
package spi_pkg;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_STAT  = 2'd2;
    localparam logic [1:0] REG_IRQEN = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CPOL   = 1;
    localparam int CTRL_CPHA   = 2;
    localparam int CTRL_LSB    = 3;
    localparam int CTRL_RX_EN  = 4;
    localparam int CTRL_CS_LO  = 8;
    localparam int CTRL_DIV_LO = 16;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_RX_FULL  = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_TX_OVF   = 6;
    localparam int STAT_LEVEL_LO = 16;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = mask[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level output; a push into a full FIFO is dropped
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_fifo_master.sv
// rtl/spi_fifo_master.sv - memory-mapped SPI master with TX/RX FIFOs, clock divider and all CPOL/CPHA modes
module spi_fifo_master
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CS     = 2,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address_in,
    input  logic              sel_in,
    input  logic              read_in,
    input  logic [3:0]        write_mask_in,
    input  logic [31:0]       write_value_in,
    output logic [31:0]       read_value_out,
    output logic              ready_out,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              lcd_dc,
    output logic              irq_out
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int HP_W  = $clog2(2*DATA_W + 1);
    localparam logic [HP_W-1:0] LAST_HP   = HP_W'(2*DATA_W);
    localparam logic [31:0]     CTRL_MASK = 32'h0000_0F1F | {16'((32'd1 << DIV_W) - 32'd1), 16'h0};

    spi_state_t        state, state_n;
    logic [31:0]       ctrl_q, act_ctrl, rd_data;
    logic [1:0]        irqen_q, reg_sel;
    logic              tx_ovf_q, rx_ovf_q;
    logic [DIV_W-1:0]  hcnt;
    logic [HP_W-1:0]   hp;
    logic [DATA_W-1:0] tx_sr, rx_sr, tx_word;
    logic [DATA_W:0]   tx_rdata;
    logic [DATA_W-1:0] rx_rdata;
    logic [LVL_W-1:0]  tx_level, unused_rx_level;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              wr_en, tx_push_bus, rx_pop_bus, tx_pop, rx_push;
    logic              tick, hold_go, enter_shift, mid_edge, lead, trail, sample, shift_ev;
    logic              unused_addr;

    assign unused_addr = ^{address_in[31:4], address_in[1:0]};
    assign reg_sel     = address_in[3:2];
    assign wr_en       = sel_in && !read_in && (write_mask_in != 4'b0);
    assign tx_push_bus = wr_en && (reg_sel == REG_DATA);
    assign rx_pop_bus  = sel_in && read_in && (reg_sel == REG_DATA);
    assign tx_word     = tx_rdata[DATA_W-1:0];

    sync_fifo #(.WIDTH(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push_bus),
        .wdata({write_value_in[31], write_value_in[DATA_W-1:0]}),
        .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_sr),
        .pop(rx_pop_bus), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .level(unused_rx_level)
    );

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [3:0] idx);
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (idx == i[3:0]) r[i] = 1'b0;
        end
        return r;
    endfunction

    // Transfer timing follows the CTRL snapshot taken at SETUP, not the live register.
    assign tick    = (hcnt == act_ctrl[CTRL_DIV_LO +: DIV_W]);
    assign hold_go = ctrl_q[CTRL_EN] && !tx_empty && (ctrl_q == act_ctrl);

    always_comb begin
        state_n = state;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        unique case (state)
            IDLE:  if (ctrl_q[CTRL_EN] && !tx_empty) begin
                       state_n = SETUP;
                       tx_pop  = 1'b1;
                   end
            SETUP: if (tick) state_n = SHIFT;
            SHIFT: if (tick && hp == LAST_HP) begin
                       state_n = HOLD;
                       rx_push = act_ctrl[CTRL_RX_EN];
                   end
            HOLD:  if (tick) begin
                       if (hold_go) begin
                           state_n = SHIFT;
                           tx_pop  = 1'b1;
                       end else begin
                           state_n = IDLE;
                       end
                   end
            default: state_n = IDLE;
        endcase
    end

    // Half-period hp is 1..2*DATA_W; odd half-periods start on a leading edge.
    assign enter_shift = (state_n == SHIFT) && (state != SHIFT);
    assign mid_edge    = (state == SHIFT) && tick && (hp != LAST_HP);
    assign lead        = enter_shift || (mid_edge && !hp[0]);
    assign trail       = mid_edge && hp[0];
    assign sample      = act_ctrl[CTRL_CPHA] ? trail : lead;
    assign shift_ev    = act_ctrl[CTRL_CPHA] ? lead : trail;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt     <= '0;
            hp       <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            act_ctrl <= '0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= '1;
            lcd_dc   <= 1'b0;
        end else begin
            hcnt <= (state == IDLE || tick) ? '0 : hcnt + 1'b1;
            if (state == IDLE && state_n == SETUP) begin
                act_ctrl <= ctrl_q;
                lcd_dc   <= tx_rdata[DATA_W];
                spi_clk  <= ctrl_q[CTRL_CPOL];
                spi_cs_n <= cs_decode(ctrl_q[CTRL_CS_LO +: 4]);
                if (ctrl_q[CTRL_CPHA]) begin
                    tx_sr <= tx_word;
                end else begin
                    spi_mosi <= first_bit(tx_word, ctrl_q[CTRL_LSB]);
                    tx_sr    <= shift_out(tx_word, ctrl_q[CTRL_LSB]);
                end
            end
            if (enter_shift) begin
                hp      <= HP_W'(1);
                spi_clk <= ~act_ctrl[CTRL_CPOL];
            end else if (mid_edge) begin
                hp      <= hp + 1'b1;
                spi_clk <= ~spi_clk;
            end
            if (state == HOLD && state_n == SHIFT) begin
                lcd_dc   <= tx_rdata[DATA_W];
                spi_mosi <= first_bit(tx_word, act_ctrl[CTRL_LSB]);
                tx_sr    <= shift_out(tx_word, act_ctrl[CTRL_LSB]);
            end else if (shift_ev) begin
                spi_mosi <= first_bit(tx_sr, act_ctrl[CTRL_LSB]);
                tx_sr    <= shift_out(tx_sr, act_ctrl[CTRL_LSB]);
            end
            // Mode 0/2 back-to-back words: present the next first bit before its leading edge.
            if (!act_ctrl[CTRL_CPHA] && state_n == HOLD) begin
                spi_mosi <= first_bit(tx_word, act_ctrl[CTRL_LSB]);
            end
            if (sample) begin
                rx_sr <= act_ctrl[CTRL_LSB] ? {spi_miso, rx_sr[DATA_W-1:1]}
                                            : {rx_sr[DATA_W-2:0], spi_miso};
            end
            if (state != IDLE && state_n == IDLE) spi_cs_n <= '1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA:  if (!rx_empty) rd_data[DATA_W-1:0] = rx_rdata;
            REG_CTRL:  rd_data = ctrl_q;
            REG_STAT:  begin
                rd_data[STAT_BUSY]     = (state != IDLE);
                rd_data[STAT_TX_FULL]  = tx_full;
                rd_data[STAT_TX_EMPTY] = tx_empty;
                rd_data[STAT_RX_EMPTY] = rx_empty;
                rd_data[STAT_RX_FULL]  = rx_full;
                rd_data[STAT_RX_OVF]   = rx_ovf_q;
                rd_data[STAT_TX_OVF]   = tx_ovf_q;
                rd_data[STAT_LEVEL_LO +: LVL_W] = tx_level;
            end
            default:   rd_data[1:0] = irqen_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_out      <= 1'b0;
            read_value_out <= '0;
            ctrl_q         <= '0;
            irqen_q        <= '0;
            tx_ovf_q       <= 1'b0;
            rx_ovf_q       <= 1'b0;
        end else begin
            ready_out      <= sel_in;
            read_value_out <= (sel_in && read_in) ? rd_data : '0;
            if (wr_en && reg_sel == REG_CTRL) begin
                ctrl_q <= byte_merge(ctrl_q, write_value_in, write_mask_in) & CTRL_MASK;
            end
            if (wr_en && reg_sel == REG_IRQEN && write_mask_in[0]) begin
                irqen_q <= write_value_in[1:0];
            end
            if (tx_push_bus && tx_full && !tx_pop) begin
                tx_ovf_q <= 1'b1;
            end else if (wr_en && reg_sel == REG_STAT && write_mask_in[0] && write_value_in[STAT_TX_OVF]) begin
                tx_ovf_q <= 1'b0;
            end
            if (rx_push && rx_full && !rx_pop_bus) begin
                rx_ovf_q <= 1'b1;
            end else if (wr_en && reg_sel == REG_STAT && write_mask_in[0] && write_value_in[STAT_RX_OVF]) begin
                rx_ovf_q <= 1'b0;
            end
        end
    end

    assign irq_out = |(irqen_q & {!rx_empty, tx_empty});

endmodule
